tmu2_fmlwarb: RTL and testbench

- Round-robin arbiter and FML write sequencer for two TMU burst assemblers.
- Each requester presents a completed 256-bit burst with a 16-bit word-granular select mask.
- The block picks a requester and latches its burst, then runs one 4-beat FML write transaction (64 bits per beat), expanding the word selects to byte selects.
- It sits between the TMU output burst assemblers and the FML write port of the memory controller.

---
 rtl/tmu2_fmlwarb.sv | 180 ++++++++++++++++++
 tb/tb_tmu2_fmlwarb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmu2_fmlwarb.sv
// Round-robin arbiter between two TMU burst assemblers feeding one FML write port.
// A granted burst is latched in its ack cycle, then written as a single 4-beat FML
// transaction with word selects widened to byte selects.
module tmu2_fmlwarb #(
    parameter int unsigned fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,

    output logic                 busy,

    input  logic                 pipe0_stb_i,
    output logic                 pipe0_ack_o,
    input  logic [fml_depth-6:0] burst0_addr,
    input  logic [15:0]          burst0_sel,
    input  logic [255:0]         burst0_do,

    input  logic                 pipe1_stb_i,
    output logic                 pipe1_ack_o,
    input  logic [fml_depth-6:0] burst1_addr,
    input  logic [15:0]          burst1_sel,
    input  logic [255:0]         burst1_do,

    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StBeat1,
        StBeat2,
        StBeat3
    } state_e;

    state_e               state_q, state_d;
    // 1 when requester 1 was served last, so requester 0 wins the next tie
    logic                 last_q, last_d;
    // Beat 0 goes straight to the output registers; only beats 1-3 are kept here
    logic [191:0]         data_q, data_d;
    logic [11:0]          sel_q, sel_d;
    logic [fml_depth-1:0] fml_adr_q, fml_adr_d;
    logic                 fml_stb_q, fml_stb_d;
    logic [7:0]           fml_sel_q, fml_sel_d;
    logic [63:0]          fml_do_q, fml_do_d;

    logic                 gnt0, gnt1;
    logic [fml_depth-6:0] g_addr;
    logic [15:0]          g_sel;
    logic [255:0]         g_do;

    // Each word-select bit covers two adjacent bytes of the 64-bit beat
    function automatic logic [7:0] expand_sel(input logic [3:0] nib);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[2*i +: 2] = {2{nib[i]}};
        end
        return r;
    endfunction

    // Grant decision: only in IDLE and out of reset, at most one requester per cycle
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && sys_rst_n) begin
            if (pipe0_stb_i && pipe1_stb_i) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = pipe0_stb_i;
                gnt1 = pipe1_stb_i;
            end
        end
    end

    // Mux the granted requester's burst
    always_comb begin
        g_addr = gnt1 ? burst1_addr : burst0_addr;
        g_sel  = gnt1 ? burst1_sel  : burst0_sel;
        g_do   = gnt1 ? burst1_do   : burst0_do;
    end

    // Next-state and next-output computation for the write sequencer
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        data_d    = data_q;
        sel_d     = sel_q;
        fml_adr_d = fml_adr_q;
        fml_stb_d = fml_stb_q;
        fml_sel_d = '0;
        fml_do_d  = '0;
        case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    last_d = gnt1;
                    // An empty burst is acknowledged but never reaches the bus
                    if (g_sel != 16'h0000) begin
                        state_d   = StAddr;
                        fml_stb_d = 1'b1;
                        fml_adr_d = {g_addr, 5'b00000};
                        fml_sel_d = expand_sel(g_sel[15:12]);
                        fml_do_d  = g_do[255:192];
                        data_d    = g_do[191:0];
                        sel_d     = g_sel[11:0];
                    end
                end
            end
            StAddr: begin
                // Hold beat 0 until the controller accepts the request
                fml_sel_d = fml_sel_q;
                fml_do_d  = fml_do_q;
                if (fml_ack) begin
                    state_d   = StBeat1;
                    fml_stb_d = 1'b0;
                    fml_sel_d = expand_sel(sel_q[11:8]);
                    fml_do_d  = data_q[191:128];
                end
            end
            StBeat1: begin
                state_d   = StBeat2;
                fml_sel_d = expand_sel(sel_q[7:4]);
                fml_do_d  = data_q[127:64];
            end
            StBeat2: begin
                state_d   = StBeat3;
                fml_sel_d = expand_sel(sel_q[3:0]);
                fml_do_d  = data_q[63:0];
            end
            StBeat3: begin
                state_d = StIdle;
            end
            default: begin
                state_d   = StIdle;
                fml_stb_d = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs; reset discards any in-flight burst
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            data_q    <= '0;
            sel_q     <= '0;
            fml_adr_q <= '0;
            fml_stb_q <= 1'b0;
            fml_sel_q <= '0;
            fml_do_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            fml_adr_q <= fml_adr_d;
            fml_stb_q <= fml_stb_d;
            fml_sel_q <= fml_sel_d;
            fml_do_q  <= fml_do_d;
        end
    end

    // Output mapping
    always_comb begin
        busy        = (state_q != StIdle);
        pipe0_ack_o = gnt0;
        pipe1_ack_o = gnt1;
        fml_adr     = fml_adr_q;
        fml_stb     = fml_stb_q;
        fml_we      = fml_stb_q;
        fml_sel     = fml_sel_q;
        fml_do      = fml_do_q;
    end

endmodule

// File: tb/tb_tmu2_fmlwarb.sv
// Scoreboard bench for tmu2_fmlwarb: expected grants and beats are queued as
// stimulus is issued; a monitor pops and compares whenever the DUT acks or beats.
module tb_tmu2_fmlwarb;

    localparam int AW = 21;

    typedef struct packed {
        logic [25:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
    } beat_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          busy;
    logic          pipe0_stb_i, pipe0_ack_o;
    logic [AW-1:0] burst0_addr;
    logic [15:0]   burst0_sel;
    logic [255:0]  burst0_do;
    logic          pipe1_stb_i, pipe1_ack_o;
    logic [AW-1:0] burst1_addr;
    logic [15:0]   burst1_sel;
    logic [255:0]  burst1_do;
    logic [25:0]   fml_adr;
    logic          fml_stb, fml_we;
    logic          fml_ack = 1'b0;
    logic [7:0]    fml_sel;
    logic [63:0]   fml_do;

    tmu2_fmlwarb #(.fml_depth(26)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .busy        (busy),
        .pipe0_stb_i (pipe0_stb_i),
        .pipe0_ack_o (pipe0_ack_o),
        .burst0_addr (burst0_addr),
        .burst0_sel  (burst0_sel),
        .burst0_do   (burst0_do),
        .pipe1_stb_i (pipe1_stb_i),
        .pipe1_ack_o (pipe1_ack_o),
        .burst1_addr (burst1_addr),
        .burst1_sel  (burst1_sel),
        .burst1_do   (burst1_do),
        .fml_adr     (fml_adr),
        .fml_stb     (fml_stb),
        .fml_we      (fml_we),
        .fml_ack     (fml_ack),
        .fml_sel     (fml_sel),
        .fml_do      (fml_do)
    );

    always #5 sys_clk = ~sys_clk;

    int    cyc = 0;
    int    total = 0;
    int    passed = 0;
    int    ack_delay = 0;
    int    wait_cnt = 0;
    int    beat_cnt = 0;
    int    exp_gnt[$];
    int    gnt_cyc[$];
    beat_t exp_beats[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    // Reference beat: 64-bit slice, and each word-select bit replicated onto two bytes
    function automatic beat_t mk_beat(input logic [AW-1:0] a, input logic [15:0] s,
                                      input logic [255:0] d, input int b);
        beat_t        r;
        logic [255:0] sh;
        logic [15:0]  ss;
        sh    = d >> (64 * (3 - b));
        ss    = s >> (4 * (3 - b));
        r.dat = sh[63:0];
        for (int j = 0; j < 8; j++) r.sel[j] = ss[j / 2];
        r.adr = {a, 5'b00000};
        return r;
    endfunction

    task automatic push_burst(input logic [AW-1:0] a, input logic [15:0] s,
                              input logic [255:0] d, input int nbeats);
        for (int b = 0; b < nbeats; b++) exp_beats.push_back(mk_beat(a, s, d, b));
    endtask

    task automatic push_beat(input logic [25:0] a, input logic [7:0] s, input logic [63:0] d);
        beat_t r;
        r.adr = a;
        r.sel = s;
        r.dat = d;
        exp_beats.push_back(r);
    endtask

    // FML slave model: acknowledges ack_delay cycles after fml_stb rises
    always begin
        @(posedge sys_clk);
        #1;
        if (fml_stb && !fml_ack) begin
            if (wait_cnt >= ack_delay) begin
                fml_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            fml_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: compare grants and bus beats against the scoreboard queues
    always @(negedge sys_clk) begin
        if (pipe0_ack_o === 1'b1 || pipe1_ack_o === 1'b1) begin
            chk("ack_onehot", {127'd0, pipe0_ack_o & pipe1_ack_o}, 128'd0);
            gnt_cyc.push_back(cyc);
            if (exp_gnt.size() == 0) begin
                fail_now("unexpected_ack");
            end else begin
                int g;
                g = exp_gnt.pop_front();
                chk("grant_id", {127'd0, pipe1_ack_o}, 128'(g));
            end
        end
        if (fml_stb === 1'b1 && fml_ack === 1'b1) begin
            if (exp_beats.size() == 0) begin
                fail_now("unexpected_beat0");
            end else begin
                beat_t e;
                e = exp_beats.pop_front();
                chk("beat0_adr", 128'(fml_adr), 128'(e.adr));
                chk("beat0_sel", 128'(fml_sel), 128'(e.sel));
                chk("beat0_do", 128'(fml_do), 128'(e.dat));
                chk("beat0_we", 128'(fml_we), 128'd1);
            end
            beat_cnt = 3;
        end else if (beat_cnt > 0) begin
            if (exp_beats.size() == 0) begin
                fail_now("missing_expected_beat");
            end else begin
                beat_t e;
                e = exp_beats.pop_front();
                chk("beat_sel", 128'(fml_sel), 128'(e.sel));
                chk("beat_do", 128'(fml_do), 128'(e.dat));
                chk("beat_stb_low", 128'(fml_stb), 128'd0);
            end
            beat_cnt--;
        end
        if (sys_rst_n === 1'b0) beat_cnt = 0;
    end

    task automatic send(input int id, input logic [AW-1:0] a, input logic [15:0] s,
                        input logic [255:0] d);
        bit got;
        got = 1'b0;
        @(posedge sys_clk);
        #1;
        if (id == 0) begin
            pipe0_stb_i = 1'b1; burst0_addr = a; burst0_sel = s; burst0_do = d;
        end else begin
            pipe1_stb_i = 1'b1; burst1_addr = a; burst1_sel = s; burst1_do = d;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            if ((id == 0) ? pipe0_ack_o : pipe1_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("ack_timeout");
    endtask

    task automatic drop(input int id);
        @(posedge sys_clk);
        #1;
        if (id == 0) pipe0_stb_i = 1'b0;
        else pipe1_stb_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_beats.size() == 0 && exp_gnt.size() == 0 && !busy) break;
            @(negedge sys_clk);
        end
        chk(name, 128'(exp_beats.size() + exp_gnt.size() + int'(busy)), 128'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stb"}, 128'(fml_stb), 128'd0);
        chk({tag, "_we"}, 128'(fml_we), 128'd0);
        chk({tag, "_sel"}, 128'(fml_sel), 128'd0);
        chk({tag, "_do"}, 128'(fml_do), 128'd0);
        chk({tag, "_adr"}, 128'(fml_adr), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_acks"}, 128'({pipe0_ack_o, pipe1_ack_o}), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [255:0] da, db, dc, dd;
        int           errs;
        bit           seen;

        sys_rst_n   = 1'b0;
        pipe0_stb_i = 1'b1;  // requests during reset must not be acked
        pipe1_stb_i = 1'b0;
        burst0_addr = '0; burst0_sel = 16'hFFFF; burst0_do = '0;
        burst1_addr = '0; burst1_sel = '0;       burst1_do = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset_outputs("reset");
        pipe0_stb_i = 1'b0;
        sys_rst_n   = 1'b1;

        // Single burst, ack 3 cycles after stb
        ack_delay = 3;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(k);
        exp_gnt.push_back(0);
        push_beat(26'h2468A0, 8'hFF, 64'h000F_000E_000D_000C);
        push_beat(26'h2468A0, 8'hFF, 64'h000B_000A_0009_0008);
        push_beat(26'h2468A0, 8'hFF, 64'h0007_0006_0005_0004);
        push_beat(26'h2468A0, 8'hFF, 64'h0003_0002_0001_0000);
        send(0, 21'h12345, 16'hFFFF, d);
        drop(0);
        repeat (7) @(negedge sys_clk);
        chk("busy_in_beat3", 128'(busy), 128'd1);
        @(negedge sys_clk);
        chk("busy_after_beat3", 128'(busy), 128'd0);
        drain("drain_single");

        // Partial mask
        ack_delay = 1;
        d = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        exp_gnt.push_back(0);
        push_beat(26'h0015780, 8'hC0, 64'h1111_1111_1111_1111);
        push_beat(26'h0015780, 8'h00, 64'h2222_2222_2222_2222);
        push_beat(26'h0015780, 8'h00, 64'h3333_3333_3333_3333);
        push_beat(26'h0015780, 8'h03, 64'h4444_4444_4444_4444);
        send(0, 21'h00ABC, 16'h8001, d);
        drop(0);
        drain("drain_partial");

        // Empty burst from requester 1
        exp_gnt.push_back(1);
        send(1, 21'h00005, 16'h0000, d);
        drop(1);
        seen = 1'b0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (fml_stb) seen = 1'b1;
            if (busy) errs++;
        end
        chk("empty_no_stb", 128'(seen), 128'd0);
        chk("empty_no_busy", 128'(errs), 128'd0);
        drain("drain_empty");

        // Contention: both held for two bursts each, immediate fml_ack
        ack_delay = 0;
        gnt_cyc.delete();
        da = {64'hA000_0000_0000_0003, 64'hA000_0000_0000_0002,
              64'hA000_0000_0000_0001, 64'hA000_0000_0000_0000};
        db = {64'hB3B3_B3B3_0000_FFFF, 64'hB2B2_B2B2_1111_EEEE,
              64'hB1B1_B1B1_2222_DDDD, 64'hB0B0_B0B0_3333_CCCC};
        dc = ~da;
        dd = ~db;
        exp_gnt.push_back(0); push_burst(21'h00100, 16'hF0F0, da, 4);
        exp_gnt.push_back(1); push_burst(21'h00200, 16'h0FF0, db, 4);
        exp_gnt.push_back(0); push_burst(21'h00300, 16'h1234, dc, 4);
        exp_gnt.push_back(1); push_burst(21'h00400, 16'hFFFF, dd, 4);
        fork
            begin
                send(0, 21'h00100, 16'hF0F0, da);
                send(0, 21'h00300, 16'h1234, dc);
                drop(0);
            end
            begin
                send(1, 21'h00200, 16'h0FF0, db);
                send(1, 21'h00400, 16'hFFFF, dd);
                drop(1);
            end
        join
        drain("drain_contention");
        chk("contention_grants", 128'(gnt_cyc.size()), 128'd4);
        if (gnt_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("grant_spacing", 128'(gnt_cyc[i] - gnt_cyc[i-1]), 128'd5);
        end

        // Stalled bus: 50-cycle ack delay while requester 1 waits with an empty burst
        ack_delay = 50;
        d = {64'hCAFE_0000_BEEF_0001, 64'hCAFE_0000_BEEF_0002,
             64'hCAFE_0000_BEEF_0003, 64'hCAFE_0000_BEEF_0004};
        exp_gnt.push_back(0); push_burst(21'h1ABCD, 16'hC3A5, d, 4);
        exp_gnt.push_back(1);
        errs = 0;
        fork
            begin
                send(0, 21'h1ABCD, 16'hC3A5, d);
                drop(0);
            end
            begin
                send(1, 21'h0BEEF, 16'h0000, da);
                drop(1);
            end
            begin
                beat_t e;
                e = mk_beat(21'h1ABCD, 16'hC3A5, d, 0);
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge sys_clk);
                    if (fml_stb) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("stall_stb_rise", 128'(seen), 128'd1);
                for (int i = 0; i < 40; i++) begin
                    @(negedge sys_clk);
                    if (fml_stb !== 1'b1 || fml_adr !== e.adr || fml_sel !== e.sel ||
                        fml_do !== e.dat || pipe0_ack_o || pipe1_ack_o) errs++;
                end
                chk("stall_hold", 128'(errs), 128'd0);
            end
        join
        drain("drain_stall");

        // Reset during BEAT2, then requester 0 must win the next tie
        ack_delay = 0;
        d = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
        exp_gnt.push_back(0); push_burst(21'h0F0F0, 16'hFFFF, d, 3);
        send(0, 21'h0F0F0, 16'hFFFF, d);
        drop(0);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        chk("busy_before_reset", 128'(busy), 128'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_reset_outputs("midreset");
        sys_rst_n = 1'b1;
        exp_gnt.push_back(0); push_burst(21'h00777, 16'h0F00, dd, 4);
        exp_gnt.push_back(1);
        fork
            begin
                send(0, 21'h00777, 16'h0F00, dd);
                drop(0);
            end
            begin
                send(1, 21'h00888, 16'h0000, dc);
                drop(1);
            end
        join
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
